window_gen_3x3: RTL and testbench

//  Converts a raster-order pixel stream into a registered 3x3 neighbourhood for the 3x3 smoothing stage.

---
 rtl/window_gen_3x3.sv | 118 +++++++++++
 tb/tb_window_gen_3x3.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
//   Turns a raster-order pixel stream into a registered 3x3 neighbourhood for
//   the downstream 3x3 smoothing stage. Two line buffers hold rows r-1 and r-2.
//   The window is three rows of 3-deep column shift registers. A window is
//   flagged valid only when all nine taps are real pixels of the current frame.
//
//   Ports
//     clk, rst_n      : clock, async active-low reset
//     pixel_in        : input pixel, raster order
//     pixel_valid     : pixel accepted on every rising edge where high
//     w1..w9          : taps, row-major (w1 = (r-2,c-2) ... w9 = (r,c))
//     win_valid       : one-cycle pulse, taps hold a complete window
//     cen_row/cen_col : coordinates of the centre tap w5
//     frame_done      : one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module window_gen_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              pixel_valid,
  output logic [DATA_W-1:0] w1,
  output logic [DATA_W-1:0] w2,
  output logic [DATA_W-1:0] w3,
  output logic [DATA_W-1:0] w4,
  output logic [DATA_W-1:0] w5,
  output logic [DATA_W-1:0] w6,
  output logic [DATA_W-1:0] w7,
  output logic [DATA_W-1:0] w8,
  output logic [DATA_W-1:0] w9,
  output logic              win_valid,
  output logic [RW-1:0]     cen_row,
  output logic [CW-1:0]     cen_col,
  output logic              frame_done
);

  logic              accept;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              col_last, row_last;

  assign accept   = pixel_valid;
  assign col_last = (col_q == CW'(IMG_W-1));
  assign row_last = (row_q == RW'(IMG_H-1));

  // Raster position of the pixel being accepted this cycle.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) row_d = row_last ? '0 : row_q + 1'b1;
    end
  end

  // Line buffers: no reset. Stale contents only reach taps in rows 0/1 of a
  // frame, where win_valid is held low.
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb2_q [IMG_W];
  logic [DATA_W-1:0] lb1_rd, lb2_rd;

  assign lb1_rd = lb1_q[col_q];
  assign lb2_rd = lb2_q[col_q];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= pixel_in;
      lb2_q[col_q] <= lb1_rd;
    end
  end

  // win_q[row][col]: row 0 = r-2 (top), col 0 = leftmost tap.
  logic [2:0][2:0][DATA_W-1:0] win_q;
  logic [2:0][DATA_W-1:0]      col_in;

  assign col_in = {pixel_in, lb1_rd, lb2_rd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      win_valid  <= 1'b0;
      cen_row    <= '0;
      cen_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win_valid  <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
      frame_done <= accept && row_last && col_last;
      if (accept) begin
        // Shift every row left one column; the new column enters on the right.
        for (int k = 0; k < 3; k++)
          win_q[k] <= {col_in[k], win_q[k][2:1]};
        cen_row <= row_q - 1'b1;
        cen_col <= col_q - 1'b1;
      end
    end
  end

  assign w1 = win_q[0][0];
  assign w2 = win_q[0][1];
  assign w3 = win_q[0][2];
  assign w4 = win_q[1][0];
  assign w5 = win_q[1][1];
  assign w6 = win_q[1][2];
  assign w7 = win_q[2][0];
  assign w8 = win_q[2][1];
  assign w9 = win_q[2][2];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 at IMG_W=8, IMG_H=6.
// Pixel value = {row[3:0],col[3:0]} (or 0xFF for the flat frame).
module tb_window_gen_3x3;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          clk, rst_n;
  logic [DW-1:0] pixel_in;
  logic          pixel_valid;
  logic [DW-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic          win_valid, frame_done;
  logic [2:0]    cen_row, cen_col;

  window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8), .w9(w9),
    .win_valid(win_valid), .cen_row(cen_row), .cen_col(cen_col), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int r = 0, c = 0;
  int nwin, nfd;
  bit flat = 0;
  bit have_last = 0;
  logic [71:0] last_win;

  wire [71:0] taps = {w1, w2, w3, w4, w5, w6, w7, w8, w9};
  wire [79:0] all_out = {taps, win_valid, cen_row, cen_col, frame_done};

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (r=%0d c=%0d)", tag, got, exp, r, c);
    end
  endtask

  function automatic logic [7:0] pix(input int pr, input int pc);
    return flat ? 8'hFF : {pr[3:0], pc[3:0]};
  endfunction

  // One clock: drive, then check the outputs produced by that edge.
  task automatic step(input bit v);
    logic [71:0] e;
    bit ewv, efd;
    int s;
    pixel_valid = v;
    pixel_in    = v ? pix(r, c) : 8'($urandom);
    @(posedge clk); #1;
    ewv = v && r >= 2 && c >= 2;
    efd = v && r == H-1 && c == W-1;
    chk("win_valid", 80'(win_valid), 80'(ewv));
    chk("frame_done", 80'(frame_done), 80'(efd));
    if (efd) nfd++;
    if (ewv) begin
      e = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e[71-8*(3*i+j) -: 8] = pix(r-2+i, c-2+j);
      chk("taps", 80'(taps), 80'(e));
      chk("cen", 80'({cen_row, cen_col}), 80'({3'(r-1), 3'(c-1)}));
      if (!flat && r == 2 && c == 2)
        chk("first_win", 80'(taps), 80'(72'h00_01_02_10_11_12_20_21_22));
      if (!flat && r == 5 && c == 7) begin
        chk("last_w5", 80'(w5), 80'(8'h46));
        chk("last_w9", 80'(w9), 80'(8'h57));
        chk("last_cen", 80'({cen_row, cen_col}), 80'({3'd4, 3'd6}));
      end
      if (flat) begin
        s = w1 + w2 + w3 + w4 + w5 + w6 + w7 + w8 + w9;
        chk("smooth", 80'(s / 9), 80'(255));
      end
      nwin++;
      last_win  = e;
      have_last = 1;
    end else if (!v && have_last) begin
      chk("hold", 80'(taps), 80'(last_win));
    end
    if (v) begin
      if (!ewv) have_last = 0;
      if (c == W-1) begin
        c = 0;
        r = (r == H-1) ? 0 : r + 1;
      end else c++;
    end
  endtask

  // Feed n accepted pixels with the given idle percentage.
  task automatic feed(input int n, input int idle_pct);
    int acc = 0;
    while (acc < n) begin
      if ($urandom_range(0, 99) >= idle_pct) begin
        step(1); acc++;
      end else step(0);
    end
  endtask

  task automatic frame(input int idle_pct);
    nwin = 0; nfd = 0;
    feed(W*H, idle_pct);
    step(0);
    chk("nwin", 80'(nwin), 80'(24));
    chk("nfd", 80'(nfd), 80'(1));
  endtask

  initial begin
    // 1: reset held with pixel_valid toggling
    rst_n = 0; pixel_valid = 0; pixel_in = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      pixel_valid = i[0];
      @(posedge clk); #1;
      chk("rst_hold", all_out, '0);
    end
    @(negedge clk); rst_n = 1; pixel_valid = 0;

    // 2: continuous frame
    frame(0);
    // 3: same frame with 30% idle
    frame(30);
    // 4: two frames back to back
    frame(0);
    frame(0);

    // 5: reset mid-frame after pixel (3,4)
    nwin = 0;
    feed(3*W + 5, 0);
    #2 rst_n = 0;
    #1 chk("rst_async", all_out, '0);
    for (int i = 0; i < 3; i++) begin
      pixel_valid = i[0]; pixel_in = 8'h5A;
      @(posedge clk); #1;
      chk("rst_mid", all_out, '0);
    end
    @(negedge clk); rst_n = 1; pixel_valid = 0;
    r = 0; c = 0; have_last = 0;
    frame(0);

    // 6: flat 0xFF frame
    flat = 1;
    frame(0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
